// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the alarm-clock mode sequencer.
//  - 3-bit state encoding and the state enum built on it
//  - mode_leds pattern for each state and a decode helper
//  - default alarm / snooze durations and the tick-counter width
//  - bit positions of the synchronized input vector used in the top level
package clock_ctrl_pkg;

  localparam int CNT_W                = 16;
  localparam int ALARM_TICKS_DEFAULT  = 12000;  // 60 s at 200 Hz
  localparam int SNOOZE_TICKS_DEFAULT = 60000;  // 5 min at 200 Hz

  localparam logic [2:0] ENC_CLOCK        = 3'd0;
  localparam logic [2:0] ENC_ADJ_CLK_HOUR = 3'd1;
  localparam logic [2:0] ENC_ADJ_CLK_MIN  = 3'd2;
  localparam logic [2:0] ENC_ADJ_ALM_HOUR = 3'd3;
  localparam logic [2:0] ENC_ADJ_ALM_MIN  = 3'd4;

  typedef enum logic [2:0] {
    ST_CLOCK        = ENC_CLOCK,
    ST_ADJ_CLK_HOUR = ENC_ADJ_CLK_HOUR,
    ST_ADJ_CLK_MIN  = ENC_ADJ_CLK_MIN,
    ST_ADJ_ALM_HOUR = ENC_ADJ_ALM_HOUR,
    ST_ADJ_ALM_MIN  = ENC_ADJ_ALM_MIN
  } state_e;

  localparam logic [3:0] LEDS_CLOCK    = 4'b0000;
  localparam logic [3:0] LEDS_CLK_HOUR = 4'b0001;
  localparam logic [3:0] LEDS_CLK_MIN  = 4'b0010;
  localparam logic [3:0] LEDS_ALM_HOUR = 4'b0100;
  localparam logic [3:0] LEDS_ALM_MIN  = 4'b1000;

  // Positions in the vector of synchronized inputs.
  localparam int IN_NUM    = 5;
  localparam int IDX_MODE  = 0;
  localparam int IDX_NEXT  = 1;
  localparam int IDX_UP    = 2;
  localparam int IDX_DOWN  = 3;
  localparam int IDX_MATCH = 4;

  function automatic logic [3:0] leds_of(input state_e s);
    case (s)
      ST_ADJ_CLK_HOUR: return LEDS_CLK_HOUR;
      ST_ADJ_CLK_MIN:  return LEDS_CLK_MIN;
      ST_ADJ_ALM_HOUR: return LEDS_ALM_HOUR;
      ST_ADJ_ALM_MIN:  return LEDS_ALM_MIN;
      default:         return LEDS_CLOCK;
    endcase
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for one asynchronous pin.
// Ports:
//  clk    in  sampling clock
//  rst    in  synchronous, active-high reset (clears the whole pipeline)
//  din    in  raw asynchronous input
//  level  out synchronized level (second flop)
//  pulse  out one-cycle pulse on a synchronized 0->1 transition; holding the
//             input high produces exactly one pulse
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic pulse
);

  // [0] metastability catcher, [1] synchronized level, [2] previous level
  logic [2:0] shift_q, shift_d;

  always_comb begin
    shift_d = {shift_q[1:0], din};
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values; blocking
    // assignments here would make the result depend on statement order.
    if (rst) shift_q <= '0;
    else     shift_q <= shift_d;
  end

  assign level = shift_q[1];
  assign pulse = shift_q[1] & ~shift_q[2];

endmodule

// File: rtl/clock_mode_controller.sv
// Mode sequencer for the digital alarm clock. Turns the board buttons into the
// run/adjust strobes for the clock and alarm counters, selects which time the
// display shows and drives the alarm buzzer.
// Ports (all synchronous to clk200Hz, rst is synchronous active-high):
//  btn_mode, btn_next, btn_up, btn_down  raw buttons
//  alarm_match            alarm time == clock time, asynchronous
//  en_en                  clock counter run enable (0 while adjusting clock)
//  adjust_en_min/hour     clock field adjust enables
//  adjust_alarm_en_min/hour  alarm field adjust enables
//  updown                 adjust direction, 1 = up
//  segment_display_flag   1 = show alarm time
//  alarm_on               buzzer/LED drive
//  mode_leds              one-hot adjust-field indicator, 0000 in CLOCK
// Build option: define CLOCK_CTRL_SNOOZE_EN to make btn_next snooze a ringing
// alarm for SNOOZE_TICKS cycles; otherwise btn_next dismisses like btn_mode.
module clock_mode_controller
  import clock_ctrl_pkg::*;
#(
  parameter int ALARM_TICKS  = ALARM_TICKS_DEFAULT,
  parameter int SNOOZE_TICKS = SNOOZE_TICKS_DEFAULT
) (
  input  logic       clk200Hz,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       alarm_match,
  output logic       en_en,
  output logic       adjust_en_min,
  output logic       adjust_en_hour,
  output logic       adjust_alarm_en_min,
  output logic       adjust_alarm_en_hour,
  output logic       updown,
  output logic       segment_display_flag,
  output logic       alarm_on,
  output logic [3:0] mode_leds
);

  localparam logic [CNT_W-1:0] RING_LOAD = CNT_W'(ALARM_TICKS - 1);
`ifdef CLOCK_CTRL_SNOOZE_EN
  localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_TICKS - 1);
`else
  localparam int unused_snooze_ticks = SNOOZE_TICKS;
`endif

  // ---------------- input synchronization ----------------
  logic [IN_NUM-1:0] pin_vec, level_vec, pulse_vec;

  assign pin_vec = {alarm_match, btn_down, btn_up, btn_next, btn_mode};

  for (genvar i = 0; i < IN_NUM; i++) begin : g_sync
    btn_sync_edge u_sync (
      .clk   (clk200Hz),
      .rst   (rst),
      .din   (pin_vec[i]),
      .level (level_vec[i]),
      .pulse (pulse_vec[i])
    );
  end

  // Up/down are used as levels; mode/next/match only as edges.
  logic unused_sync;
  assign unused_sync = ^{level_vec[IDX_MODE], level_vec[IDX_NEXT],
                         level_vec[IDX_MATCH], pulse_vec[IDX_UP],
                         pulse_vec[IDX_DOWN]};

  logic mode_p, next_p, up_s, down_s, match_p;
  assign mode_p  = pulse_vec[IDX_MODE];
  assign next_p  = pulse_vec[IDX_NEXT];
  assign up_s    = level_vec[IDX_UP];
  assign down_s  = level_vec[IDX_DOWN];
  assign match_p = pulse_vec[IDX_MATCH];

  // ---------------- state ----------------
  state_e           state_q, state_d;
  logic             updown_q, updown_d;
  logic             alarm_on_q, alarm_on_d;
  logic [CNT_W-1:0] ring_cnt_q, ring_cnt_d;
`ifdef CLOCK_CTRL_SNOOZE_EN
  logic             snooze_pend_q, snooze_pend_d;
  logic [CNT_W-1:0] snooze_cnt_q, snooze_cnt_d;
`endif

  logic in_alm_adj, in_clk_adj, alarm_start, mode_taken, next_taken;

  assign in_alm_adj  = (state_q == ST_ADJ_ALM_HOUR) || (state_q == ST_ADJ_ALM_MIN);
  assign in_clk_adj  = (state_q == ST_ADJ_CLK_HOUR) || (state_q == ST_ADJ_CLK_MIN);
  // A match while the alarm itself is being edited is dropped, not deferred.
  assign alarm_start = match_p && !in_alm_adj;

  always_comb begin
    // NOTE: every variable gets a default first; a path that leaves one
    // unassigned would infer a latch.
    state_d    = state_q;
    updown_d   = updown_q;
    alarm_on_d = alarm_on_q;
    ring_cnt_d = ring_cnt_q;
`ifdef CLOCK_CTRL_SNOOZE_EN
    snooze_pend_d = snooze_pend_q;
    snooze_cnt_d  = snooze_cnt_q;
`endif
    mode_taken = 1'b0;
    next_taken = 1'b0;

    // Direction remembers the last unambiguous request.
    if (up_s && !down_s)      updown_d = 1'b1;
    else if (down_s && !up_s) updown_d = 1'b0;

    // Alarm: a fresh start wins over a same-cycle button, which then acts
    // on the FSM instead of dismissing.
    if (alarm_start) begin
      alarm_on_d = 1'b1;
      ring_cnt_d = RING_LOAD;
`ifdef CLOCK_CTRL_SNOOZE_EN
      snooze_pend_d = 1'b0;
`endif
    end else if (alarm_on_q) begin
      if (mode_p) begin
        alarm_on_d = 1'b0;
        ring_cnt_d = '0;
        mode_taken = 1'b1;
      end else if (next_p) begin
        alarm_on_d = 1'b0;
        ring_cnt_d = '0;
        next_taken = 1'b1;
`ifdef CLOCK_CTRL_SNOOZE_EN
        snooze_pend_d = 1'b1;
        snooze_cnt_d  = SNOOZE_LOAD;
`endif
      end else if (ring_cnt_q == '0) begin
        alarm_on_d = 1'b0;
      end else begin
        ring_cnt_d = ring_cnt_q - CNT_W'(1);
      end
    end
`ifdef CLOCK_CTRL_SNOOZE_EN
    else if (snooze_pend_q) begin
      if (mode_p) begin
        snooze_pend_d = 1'b0;
        mode_taken    = 1'b1;
      end else if (snooze_cnt_q == '0) begin
        snooze_pend_d = 1'b0;
        alarm_on_d    = 1'b1;
        ring_cnt_d    = RING_LOAD;
      end else begin
        snooze_cnt_d = snooze_cnt_q - CNT_W'(1);
      end
    end
`endif

    // Mode sequencing; presses used by the alarm never reach the FSM.
    if (mode_p && !mode_taken) begin
      if (state_q == ST_CLOCK) state_d = ST_ADJ_CLK_HOUR;
      else                     state_d = ST_CLOCK;
    end else if (next_p && !next_taken) begin
      case (state_q)
        ST_ADJ_CLK_HOUR: state_d = ST_ADJ_CLK_MIN;
        ST_ADJ_CLK_MIN:  state_d = ST_ADJ_ALM_HOUR;
        ST_ADJ_ALM_HOUR: state_d = ST_ADJ_ALM_MIN;
        ST_ADJ_ALM_MIN:  state_d = ST_ADJ_CLK_HOUR;
        default:         state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk200Hz) begin
    if (rst) begin
      state_q    <= ST_CLOCK;
      updown_q   <= 1'b1;
      alarm_on_q <= 1'b0;
      ring_cnt_q <= '0;
`ifdef CLOCK_CTRL_SNOOZE_EN
      snooze_pend_q <= 1'b0;
      snooze_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      updown_q   <= updown_d;
      alarm_on_q <= alarm_on_d;
      ring_cnt_q <= ring_cnt_d;
`ifdef CLOCK_CTRL_SNOOZE_EN
      snooze_pend_q <= snooze_pend_d;
      snooze_cnt_q  <= snooze_cnt_d;
`endif
    end
  end

  // ---------------- outputs ----------------
  logic adj_req;
  assign adj_req = up_s ^ down_s;  // both or neither held: no adjust

  assign en_en                = !in_clk_adj;  // clock keeps running during alarm edit
  assign segment_display_flag = in_alm_adj;
  assign adjust_en_hour       = adj_req && (state_q == ST_ADJ_CLK_HOUR);
  assign adjust_en_min        = adj_req && (state_q == ST_ADJ_CLK_MIN);
  assign adjust_alarm_en_hour = adj_req && (state_q == ST_ADJ_ALM_HOUR);
  assign adjust_alarm_en_min  = adj_req && (state_q == ST_ADJ_ALM_MIN);
  assign updown               = updown_q;
  assign alarm_on             = alarm_on_q;
  assign mode_leds            = leds_of(state_q);

endmodule

// File: tb/tb_clock_mode_controller.sv
// Self-checking bench for clock_mode_controller (ALARM_TICKS=8, SNOOZE_TICKS=20).
// Directed table of button vectors, hand-written alarm sequences and a
// randomized phase, all compared every cycle against a behavioural model.
module tb_clock_mode_controller;

  localparam int AT = 8;
  localparam int ST = 20;

  logic       clk200Hz = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0, btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic       alarm_match = 1'b0;
  logic       en_en, adjust_en_min, adjust_en_hour, adjust_alarm_en_min;
  logic       adjust_alarm_en_hour, updown, segment_display_flag, alarm_on;
  logic [3:0] mode_leds;

  clock_mode_controller #(.ALARM_TICKS(AT), .SNOOZE_TICKS(ST)) dut (
    .clk200Hz             (clk200Hz),
    .rst                  (rst),
    .btn_mode             (btn_mode),
    .btn_next             (btn_next),
    .btn_up               (btn_up),
    .btn_down             (btn_down),
    .alarm_match          (alarm_match),
    .en_en                (en_en),
    .adjust_en_min        (adjust_en_min),
    .adjust_en_hour       (adjust_en_hour),
    .adjust_alarm_en_min  (adjust_alarm_en_min),
    .adjust_alarm_en_hour (adjust_alarm_en_hour),
    .updown               (updown),
    .segment_display_flag (segment_display_flag),
    .alarm_on             (alarm_on),
    .mode_leds            (mode_leds)
  );

  always #5 clk200Hz = ~clk200Hz;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Pins seen after a two-edge delay; field index 0=CLOCK, 1..4 = adjust
  // fields in btn_next order. Alarm kept as "cycles left to ring".
  int         m_field;
  bit         m_ud, m_ring, m_snooze;
  int         m_ring_left, m_snooze_left;
  bit   [4:0] m_hist [3];  // [0] newest sample; bits {match,down,up,next,mode}

  always @(posedge clk200Hz) begin : model
    bit [4:0] lvl, edg;
    bit mode_used, next_used, start;
    if (rst) begin
      m_field = 0; m_ud = 1; m_ring = 0; m_snooze = 0;
      m_ring_left = 0; m_snooze_left = 0;
      for (int i = 0; i < 3; i++) m_hist[i] = '0;
    end else begin
      lvl = m_hist[1];
      edg = m_hist[1] & ~m_hist[2];
      mode_used = 0; next_used = 0;
      start = edg[4] && (m_field < 3);
      if (lvl[2] && !lvl[3]) m_ud = 1;
      else if (lvl[3] && !lvl[2]) m_ud = 0;
      if (start) begin
        m_ring = 1; m_ring_left = AT; m_snooze = 0;
      end else if (m_ring) begin
        if (edg[0]) begin m_ring = 0; mode_used = 1; end
        else if (edg[1]) begin
          m_ring = 0; next_used = 1;
`ifdef CLOCK_CTRL_SNOOZE_EN
          m_snooze = 1; m_snooze_left = ST;
`endif
        end else begin
          m_ring_left--;
          if (m_ring_left == 0) m_ring = 0;
        end
      end else if (m_snooze) begin
        if (edg[0]) begin m_snooze = 0; mode_used = 1; end
        else begin
          m_snooze_left--;
          if (m_snooze_left == 0) begin m_snooze = 0; m_ring = 1; m_ring_left = AT; end
        end
      end
      if (edg[0] && !mode_used) m_field = (m_field == 0) ? 1 : 0;
      else if (edg[1] && !next_used && m_field != 0) m_field = (m_field == 4) ? 1 : m_field + 1;
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = {alarm_match, btn_down, btn_up, btn_next, btn_mode};
    end
  end

  task automatic compare_model();
    logic [3:0] e_leds, e_adj;
    bit req;
    req    = m_hist[1][2] ^ m_hist[1][3];
    e_leds = (m_field == 0) ? 4'b0000 : 4'(1 << (m_field - 1));
    case (m_field)
      1:       e_adj = req ? 4'b0010 : 4'b0000;
      2:       e_adj = req ? 4'b0001 : 4'b0000;
      3:       e_adj = req ? 4'b1000 : 4'b0000;
      4:       e_adj = req ? 4'b0100 : 4'b0000;
      default: e_adj = 4'b0000;
    endcase
    check("mdl_leds", mode_leds, e_leds);
    check("mdl_en_en", en_en, (m_field == 1 || m_field == 2) ? 0 : 1);
    check("mdl_seg", segment_display_flag, (m_field >= 3) ? 1 : 0);
    check("mdl_adj", {adjust_alarm_en_hour, adjust_alarm_en_min, adjust_en_hour, adjust_en_min}, e_adj);
    check("mdl_updown", updown, m_ud);
    check("mdl_alarm", alarm_on, m_ring);
  endtask

  // Advance n cycles; outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk200Hz);
      compare_model();
    end
  endtask

  task automatic press(input int which);  // 0 = mode, 1 = next
    if (which == 0) btn_mode = 1; else btn_next = 1;
    step(1);
    btn_mode = 0; btn_next = 0;
  endtask

  task automatic wait_alarm(input int bound);
    int w;
    w = 0;
    while (alarm_on !== 1'b1 && w < bound) begin step(1); w++; end
    check("alarm_start_timeout", alarm_on, 1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string      name;
    logic [4:0] pins;    // {match, down, up, next, mode}
    int         cycles;
    logic [3:0] leds;
    logic       en;
    logic       seg;
    logic [3:0] adj;     // {alm_hour, alm_min, clk_hour, clk_min}
    logic       ud;
  } vec_t;

  localparam logic [4:0] P_NONE = 5'b00000, P_MODE = 5'b00001, P_NEXT = 5'b00010;
  localparam logic [4:0] P_UP = 5'b00100, P_DN = 5'b01000, P_BOTH = 5'b01100;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic [4:0] p, int c, logic [3:0] l,
                              logic e, logic s, logic [3:0] a, logic u);
    vec_t v;
    v.name = n; v.pins = p; v.cycles = c; v.leds = l;
    v.en = e; v.seg = s; v.adj = a; v.ud = u;
    return v;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : main
    int ones, zeros, first;

    vecs.push_back(mk("reset_idle",   P_NONE, 2, 4'b0000, 1, 0, 4'b0000, 1));
    vecs.push_back(mk("mode_press",   P_MODE, 1, 4'b0000, 1, 0, 4'b0000, 1));
    vecs.push_back(mk("mode_early",   P_NONE, 1, 4'b0000, 1, 0, 4'b0000, 1));
    vecs.push_back(mk("clk_hour",     P_NONE, 1, 4'b0001, 0, 0, 4'b0000, 1));
    vecs.push_back(mk("next1_press",  P_NEXT, 1, 4'b0001, 0, 0, 4'b0000, 1));
    vecs.push_back(mk("clk_min",      P_NONE, 2, 4'b0010, 0, 0, 4'b0000, 1));
    vecs.push_back(mk("next2_press",  P_NEXT, 1, 4'b0010, 0, 0, 4'b0000, 1));
    vecs.push_back(mk("alm_hour",     P_NONE, 2, 4'b0100, 1, 1, 4'b0000, 1));
    vecs.push_back(mk("next3_press",  P_NEXT, 1, 4'b0100, 1, 1, 4'b0000, 1));
    vecs.push_back(mk("alm_min",      P_NONE, 2, 4'b1000, 1, 1, 4'b0000, 1));
    vecs.push_back(mk("next4_press",  P_NEXT, 1, 4'b1000, 1, 1, 4'b0000, 1));
    vecs.push_back(mk("wrap_hour",    P_NONE, 2, 4'b0001, 0, 0, 4'b0000, 1));
    vecs.push_back(mk("hold_next",    P_NEXT, 4, 4'b0010, 0, 0, 4'b0000, 1));
    vecs.push_back(mk("hold_single",  P_NONE, 3, 4'b0010, 0, 0, 4'b0000, 1));
    vecs.push_back(mk("to_alm_hour",  P_NEXT, 1, 4'b0010, 0, 0, 4'b0000, 1));
    vecs.push_back(mk("at_alm_hour",  P_NONE, 2, 4'b0100, 1, 1, 4'b0000, 1));
    vecs.push_back(mk("to_alm_min",   P_NEXT, 1, 4'b0100, 1, 1, 4'b0000, 1));
    vecs.push_back(mk("at_alm_min",   P_NONE, 2, 4'b1000, 1, 1, 4'b0000, 1));
    vecs.push_back(mk("down_c1",      P_DN,   1, 4'b1000, 1, 1, 4'b0000, 1));
    vecs.push_back(mk("down_c2",      P_DN,   1, 4'b1000, 1, 1, 4'b0100, 1));
    vecs.push_back(mk("down_c3",      P_DN,   1, 4'b1000, 1, 1, 4'b0100, 0));
    vecs.push_back(mk("down_c4",      P_DN,   1, 4'b1000, 1, 1, 4'b0100, 0));
    vecs.push_back(mk("down_c5",      P_DN,   1, 4'b1000, 1, 1, 4'b0100, 0));
    vecs.push_back(mk("both_c1",      P_BOTH, 1, 4'b1000, 1, 1, 4'b0100, 0));
    vecs.push_back(mk("both_c2",      P_BOTH, 1, 4'b1000, 1, 1, 4'b0000, 0));
    vecs.push_back(mk("both_c4",      P_BOTH, 2, 4'b1000, 1, 1, 4'b0000, 0));
    vecs.push_back(mk("release",      P_NONE, 2, 4'b1000, 1, 1, 4'b0000, 0));
    vecs.push_back(mk("leave_press",  P_MODE, 1, 4'b1000, 1, 1, 4'b0000, 0));
    vecs.push_back(mk("back_clock",   P_NONE, 2, 4'b0000, 1, 0, 4'b0000, 0));
    vecs.push_back(mk("up_in_clock",  P_UP,   3, 4'b0000, 1, 0, 4'b0000, 1));
    vecs.push_back(mk("up_release",   P_NONE, 3, 4'b0000, 1, 0, 4'b0000, 1));

    // Reset held for two edges, then released on a falling edge.
    step(2);
    check("rst_leds", mode_leds, 4'b0000);
    check("rst_alarm", alarm_on, 0);
    rst = 0;

    foreach (vecs[i]) begin
      {alarm_match, btn_down, btn_up, btn_next, btn_mode} = vecs[i].pins;
      step(vecs[i].cycles);
      check({vecs[i].name, "/leds"}, mode_leds, vecs[i].leds);
      check({vecs[i].name, "/en_en"}, en_en, vecs[i].en);
      check({vecs[i].name, "/seg"}, segment_display_flag, vecs[i].seg);
      check({vecs[i].name, "/adj"},
            {adjust_alarm_en_hour, adjust_alarm_en_min, adjust_en_hour, adjust_en_min},
            vecs[i].adj);
      check({vecs[i].name, "/updown"}, updown, vecs[i].ud);
      check({vecs[i].name, "/alarm"}, alarm_on, 0);
    end

    // Alarm rings for exactly AT cycles, starting 3 cycles after the pin rises.
    alarm_match = 1;
    ones = 0; first = -1;
    for (int i = 1; i <= 30; i++) begin
      step(1);
      if (alarm_on === 1'b1) begin
        ones++;
        if (first < 0) first = i;
      end
    end
    check("ring_length", ones, AT);
    check("ring_latency", first, 3);
    alarm_match = 0;
    step(3);

    // btn_mode while ringing dismisses without moving the FSM.
    alarm_match = 1;
    wait_alarm(10);
    step(2);
    press(0);
    step(1);
    check("dismiss_pre", alarm_on, 1);
    step(1);
    check("dismiss_mode", alarm_on, 0);
    step(5);
    check("dismiss_leds", mode_leds, 4'b0000);
    check("dismiss_stays_off", alarm_on, 0);
    alarm_match = 0;
    step(3);

    // btn_next while ringing: snooze when compiled in, dismiss otherwise.
    alarm_match = 1;
    wait_alarm(10);
    alarm_match = 0;
    step(1);
    press(1);
    step(1);
    check("next_pre", alarm_on, 1);
    step(1);
    check("next_drop", alarm_on, 0);
`ifdef CLOCK_CTRL_SNOOZE_EN
    zeros = 1;
    while (alarm_on !== 1'b1 && zeros < 60) begin
      step(1);
      if (alarm_on !== 1'b1) zeros++;
    end
    check("snooze_len", zeros, ST);
    ones = 0;
    while (alarm_on === 1'b1 && ones < 40) begin
      step(1);
      ones++;
    end
    check("snooze_ring_len", ones, AT);
`else
    ones = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (alarm_on === 1'b1) ones++;
    end
    check("next_dismiss_quiet", ones, 0);
`endif
    check("next_leds", mode_leds, 4'b0000);
    step(3);

    // Reset in ADJ_CLK_MIN with btn_up held and the alarm ringing.
    press(0);
    step(3);
    press(1);
    step(3);
    check("pre_rst_leds", mode_leds, 4'b0010);
    btn_up = 1;
    alarm_match = 1;
    wait_alarm(10);
    check("pre_rst_adj_min", adjust_en_min, 1);
    rst = 1;
    alarm_match = 0;
    step(1);
    check("rst_en_en", en_en, 1);
    check("rst_adj",
          {adjust_alarm_en_hour, adjust_alarm_en_min, adjust_en_hour, adjust_en_min}, 4'b0000);
    check("rst_updown", updown, 1);
    check("rst_seg", segment_display_flag, 0);
    check("rst_alarm_mid", alarm_on, 0);
    check("rst_leds_mid", mode_leds, 4'b0000);
    step(1);
    rst = 0;
    btn_up = 0;
    step(3);

    // Randomized phase, checked only against the model.
    for (int c = 0; c < 3000; c++) begin
      if (btn_mode) btn_mode = ($urandom_range(0, 1) == 0);
      else          btn_mode = ($urandom_range(0, 19) == 0);
      if (btn_next) btn_next = ($urandom_range(0, 1) == 0);
      else          btn_next = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 5) == 0) btn_up = ~btn_up;
      if ($urandom_range(0, 5) == 0) btn_down = ~btn_down;
      if ($urandom_range(0, 29) == 0) alarm_match = ~alarm_match;
      rst = ($urandom_range(0, 699) == 0);
      step(1);
    end
    rst = 0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
